// File: rtl/udc_pkg.sv
// Shared constants and sizing helper for the parameterised up/down counter.
package udc_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Bits needed to hold 0..n-1, never less than one so a PRESCALE of 1 still gets a register.
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/udc_prescale.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the count.
module udc_prescale
    import udc_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt = '0;

    assign tick = en && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/udc_param.sv
// Parameterised up/down counter with prescaler, saturate/wrap end-of-range mode and parallel load.
module udc_param
    import udc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 1,
    parameter longint unsigned RESET_VAL = MAX_VAL,
    parameter int unsigned     PRESCALE  = 1
) (
    input  logic             udc_clk,
    input  logic             udc_rst,
    input  logic             udc_en,
    input  logic             udc_dir,
    input  logic             udc_sat,
    input  logic             udc_load,
    input  logic [WIDTH-1:0] udc_d,
    output logic [WIDTH-1:0] udc_q,
    output logic             udc_tc,
    output logic             udc_wrap
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic             tick;
    logic             at_end;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] q_reg    = RESET_Q;
    logic             wrap_reg = 1'b0;

    udc_prescale #(
        .PRESCALE(PRESCALE)
    ) u_prescale (
        .clk (udc_clk),
        .rst (udc_rst),
        .en  (udc_en),
        .clr (udc_load),
        .tick(tick)
    );

    assign at_end = (udc_dir == DIR_UP) ? (q_reg == MAX_Q) : (q_reg == '0);

    always_comb begin
        q_nxt    = q_reg;
        wrap_nxt = 1'b0;
        if (udc_load) begin
            q_nxt = (udc_d > MAX_Q) ? MAX_Q : udc_d;
        end else if (tick) begin
            if (!at_end) begin
                q_nxt = (udc_dir == DIR_UP) ? q_reg + 1'b1 : q_reg - 1'b1;
            end else if (udc_sat != MODE_SAT) begin
                q_nxt    = (udc_dir == DIR_UP) ? '0 : MAX_Q;
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge udc_clk) begin
        if (udc_rst) begin
            q_reg    <= RESET_Q;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_nxt;
            wrap_reg <= wrap_nxt;
        end
    end

    assign udc_q    = q_reg;
    assign udc_wrap = wrap_reg;
    assign udc_tc   = at_end;

endmodule
